// File: rtl/card_pkg.sv
// -----------------------------------------------------------------------------
// card_pkg
// Shared types, constants and helpers for the baccarat card datapath.
//   rank_t        : 4-bit card rank, 1=A, 2..10, 11=J, 12=Q, 13=K, 0=empty slot
//   deal_state_t  : deal-order states S0 -> S_P1 -> S_D1 -> S_P2 -> S_D2
//                   -> (S_P3) -> S_D3
//   SLOT_*        : slot index of each card register in the slot arrays
//   card_value()  : baccarat value of a rank (0..9)
// -----------------------------------------------------------------------------
package card_pkg;

    typedef logic [3:0] rank_t;

    typedef enum logic [2:0] {
        S0   = 3'd0,
        S_P1 = 3'd1,
        S_D1 = 3'd2,
        S_P2 = 3'd3,
        S_D2 = 3'd4,
        S_P3 = 3'd5,
        S_D3 = 3'd6
    } deal_state_t;

    localparam rank_t RANK_MIN  = 4'd1;
    localparam rank_t RANK_MAX  = 4'd13;
    localparam int    NUM_SLOTS = 6;

    // Highest rank that scores its face value; 10 and court cards score 0.
    localparam rank_t RANK_FACE_MAX = 4'd9;

    // Slot indices, player cards first, then dealer cards.
    localparam int SLOT_P1 = 0;
    localparam int SLOT_P2 = 1;
    localparam int SLOT_P3 = 2;
    localparam int SLOT_D1 = 3;
    localparam int SLOT_D2 = 4;
    localparam int SLOT_D3 = 5;

    // Empty slots (0) and out-of-range ranks (14, 15) also score 0.
    function automatic rank_t card_value(input rank_t rank);
        if ((rank >= RANK_MIN) && (rank <= RANK_FACE_MAX)) begin
            return rank;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/card_datapath_hand_score.sv
// -----------------------------------------------------------------------------
// hand_score
// Combinational baccarat score of a three-card hand.
//   card_a, card_b, card_c : input  rank_t  card ranks (0 = empty)
//   score                  : output [3:0]   (sum of card values) mod 10
// -----------------------------------------------------------------------------
module hand_score
    import card_pkg::*;
(
    input  rank_t       card_a,
    input  rank_t       card_b,
    input  rank_t       card_c,
    output logic [3:0]  score
);

    rank_t      cards  [3];
    rank_t      values [3];
    logic [4:0] sum;

    assign cards[0] = card_a;
    assign cards[1] = card_b;
    assign cards[2] = card_c;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_value
            assign values[gi] = card_value(cards[gi]);
        end
    endgenerate

    // Three values of at most 9 each give a sum of at most 27, so 5 bits hold
    // it and mod 10 reduces to at most two conditional subtractions.
    assign sum = {1'b0, values[0]} + {1'b0, values[1]} + {1'b0, values[2]};

    always_comb begin
        logic [4:0] reduced;
        reduced = sum;
        if (sum >= 5'd20) begin
            reduced = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            reduced = sum - 5'd10;
        end
        score = reduced[3:0];
    end

endmodule

// File: rtl/card_datapath.sv
// -----------------------------------------------------------------------------
// card_datapath
// Card registers, deal-order tracking and scoring for one baccarat hand.
//
// Ports
//   slow_clock               : in   the only clock, rising edge
//   resetb                   : in   synchronous reset, active high
//   load_pcard1/2/3          : in   player slot load strobes
//   load_dcard1/2/3          : in   dealer slot load strobes
//   new_card [3:0]           : in   rank being dealt (1..13)
//   pcard1/2/3, dcard1/2/3   : out  registered ranks, 0 = empty
//   pscore, dscore [3:0]     : out  hand scores 0..9
//   pcard3_val [3:0]         : out  baccarat value of pcard3
//   cards_dealt [2:0]        : out  number of slots loaded, 0..6
//   proto_err                : out  sticky load-protocol violation flag
//
// Build option
//   RANK_CHECK_EN : when defined, a load of rank 0, 14 or 15 is rejected as a
//                   protocol violation; otherwise any rank is stored as-is.
//
// Only NUM_SLOTS = 6 is supported.
// -----------------------------------------------------------------------------
module card_datapath #(
    parameter int NUM_SLOTS = 6
) (
    input  logic        slow_clock,
    input  logic        resetb,
    input  logic        load_pcard1,
    input  logic        load_pcard2,
    input  logic        load_pcard3,
    input  logic        load_dcard1,
    input  logic        load_dcard2,
    input  logic        load_dcard3,
    input  logic [3:0]  new_card,
    output logic [3:0]  pcard1,
    output logic [3:0]  pcard2,
    output logic [3:0]  pcard3,
    output logic [3:0]  dcard1,
    output logic [3:0]  dcard2,
    output logic [3:0]  dcard3,
    output logic [3:0]  pscore,
    output logic [3:0]  dscore,
    output logic [3:0]  pcard3_val,
    output logic [2:0]  cards_dealt,
    output logic        proto_err
);

    import card_pkg::*;

    deal_state_t            state_reg;
    deal_state_t            state_next;

    logic [NUM_SLOTS-1:0]   strobe;
    logic [NUM_SLOTS-1:0]   allowed_mask;
    logic [NUM_SLOTS-1:0]   occupied;
    logic [NUM_SLOTS-1:0]   slot_we;
    rank_t                  slot_q [NUM_SLOTS];

    logic                   any_strobe;
    logic                   rank_ok;
    logic                   accept;
    logic                   err_set;

    logic [2:0]             cards_dealt_reg;
    logic                   proto_err_reg;

    // Strobe vector in slot order.
    assign strobe[SLOT_P1] = load_pcard1;
    assign strobe[SLOT_P2] = load_pcard2;
    assign strobe[SLOT_P3] = load_pcard3;
    assign strobe[SLOT_D1] = load_dcard1;
    assign strobe[SLOT_D2] = load_dcard2;
    assign strobe[SLOT_D3] = load_dcard3;

    assign any_strobe = |strobe;

`ifdef RANK_CHECK_EN
    assign rank_ok = (new_card >= RANK_MIN) && (new_card <= RANK_MAX);
`else
    assign rank_ok = 1'b1;
`endif

    // A load is taken only if it is the single strobe this edge, the current
    // state expects it, its slot is still empty and the rank is acceptable.
    // Anything else with a strobe high is a violation and changes nothing
    // except the sticky error flag.
    assign accept = $onehot(strobe)
                 && ((strobe & allowed_mask) == strobe)
                 && ((strobe & occupied) == '0)
                 && rank_ok;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. The state after an accepted load is fixed by which
    // slot was loaded, so the transition is keyed on the strobe.
    // ---------------------------------------------------------------------
    always_comb begin
        allowed_mask = '0;
        state_next   = state_reg;

        case (state_reg)
            S0:      allowed_mask[SLOT_P1] = 1'b1;
            S_P1:    allowed_mask[SLOT_D1] = 1'b1;
            S_D1:    allowed_mask[SLOT_P2] = 1'b1;
            S_P2:    allowed_mask[SLOT_D2] = 1'b1;
            S_D2: begin
                // Either side may take a third card here; the dealer may
                // still draw after the player has taken one.
                allowed_mask[SLOT_P3] = 1'b1;
                allowed_mask[SLOT_D3] = 1'b1;
            end
            S_P3:    allowed_mask[SLOT_D3] = 1'b1;
            default: allowed_mask = '0;     // S_D3 is terminal
        endcase

        if (accept) begin
            if (strobe[SLOT_P1]) state_next = S_P1;
            if (strobe[SLOT_D1]) state_next = S_D1;
            if (strobe[SLOT_P2]) state_next = S_P2;
            if (strobe[SLOT_D2]) state_next = S_D2;
            if (strobe[SLOT_P3]) state_next = S_P3;
            if (strobe[SLOT_D3]) state_next = S_D3;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (slot write enables and error set)
    // ---------------------------------------------------------------------
    always_comb begin
        slot_we = '0;
        err_set = 1'b0;
        if (accept) begin
            slot_we = strobe;
        end else if (any_strobe) begin
            err_set = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Card registers. Occupancy is tracked separately from the rank so that
    // an unchecked rank-0 load still counts as a filled slot.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            rank_t card_reg;
            logic  occupied_reg;

            always_ff @(posedge slow_clock) begin
                if (resetb) begin
                    card_reg     <= '0;
                    occupied_reg <= 1'b0;
                end else if (slot_we[gi]) begin
                    card_reg     <= new_card;
                    occupied_reg <= 1'b1;
                end
            end

            assign slot_q[gi]   = card_reg;
            assign occupied[gi] = occupied_reg;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Deal counter and sticky error flag
    // ---------------------------------------------------------------------
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            cards_dealt_reg <= 3'd0;
            proto_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                cards_dealt_reg <= cards_dealt_reg + 3'd1;
            end
            if (err_set) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Scoring
    // ---------------------------------------------------------------------
    hand_score u_player_score (
        .card_a (slot_q[SLOT_P1]),
        .card_b (slot_q[SLOT_P2]),
        .card_c (slot_q[SLOT_P3]),
        .score  (pscore)
    );

    hand_score u_dealer_score (
        .card_a (slot_q[SLOT_D1]),
        .card_b (slot_q[SLOT_D2]),
        .card_c (slot_q[SLOT_D3]),
        .score  (dscore)
    );

    // Value of the player's third card alone, for the dealer draw rules.
    hand_score u_pcard3_value (
        .card_a (slot_q[SLOT_P3]),
        .card_b (4'd0),
        .card_c (4'd0),
        .score  (pcard3_val)
    );

    assign pcard1      = slot_q[SLOT_P1];
    assign pcard2      = slot_q[SLOT_P2];
    assign pcard3      = slot_q[SLOT_P3];
    assign dcard1      = slot_q[SLOT_D1];
    assign dcard2      = slot_q[SLOT_D2];
    assign dcard3      = slot_q[SLOT_D3];
    assign cards_dealt = cards_dealt_reg;
    assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_card_datapath.sv
// -----------------------------------------------------------------------------
// tb_card_datapath
// Self-checking bench for card_datapath. A reference model tracks the hand as
// a set of filled slots plus a count and decides legality from the deal rules
// (first four cards in fixed order, player third card only as the fifth card,
// dealer third card as the fifth or sixth card).
// Strobe vector bit order: {D3, D2, D1, P3, P2, P1}.
// -----------------------------------------------------------------------------
module tb_card_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
    logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
    logic [3:0] new_card = 4'd0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore, pcard3_val;
    logic [2:0] cards_dealt;
    logic       proto_err;

    int vectors    = 0;
    int miscompares = 0;

    card_datapath #(.NUM_SLOTS(6)) dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .new_card    (new_card),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3_val  (pcard3_val),
        .cards_dealt (cards_dealt),
        .proto_err   (proto_err)
    );

    always #5 slow_clock = ~slow_clock;

    localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
    localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

    wire [39:0] obs = {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
                       pscore, dscore, pcard3_val, cards_dealt, proto_err};

    // ---------------- reference model ----------------
    logic [3:0] m_cards [6];
    bit         m_loaded [6];
    int         m_count;
    bit         m_err;

    function automatic int val(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd9) ? int'(r) : 0;
    endfunction

    // Is slot s the legal next card, given what has been dealt so far?
    function automatic bit slot_legal(input int s);
        if (m_loaded[s]) return 1'b0;
        case (s)
            0: return m_count == 0;                     // P1 first
            3: return m_count == 1;                     // D1 second
            1: return m_count == 2;                     // P2 third
            4: return m_count == 3;                     // D2 fourth
            2: return m_count == 4;                     // P3 only as fifth
            5: return m_count == 4 || m_count == 5;     // D3 fifth or sixth
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit rank_acceptable(input logic [3:0] r);
`ifdef RANK_CHECK_EN
        return r >= 4'd1 && r <= 4'd13;
`else
        return r == r;
`endif
    endfunction

    function automatic void model_step(input logic [5:0] s, input logic [3:0] rank, input logic rst);
        int slot;
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_cards[i]  = 4'd0;
                m_loaded[i] = 1'b0;
            end
            m_count = 0;
            m_err   = 1'b0;
            return;
        end
        if (s == 6'b0) return;
        if ($countones(s) != 1) begin
            m_err = 1'b1;
            return;
        end
        slot = 0;
        for (int i = 0; i < 6; i++) if (s[i]) slot = i;
        if (slot_legal(slot) && rank_acceptable(rank)) begin
            m_cards[slot]  = rank;
            m_loaded[slot] = 1'b1;
            m_count++;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic logic [39:0] model_vec();
        int ps, ds;
        ps = (val(m_cards[0]) + val(m_cards[1]) + val(m_cards[2])) % 10;
        ds = (val(m_cards[3]) + val(m_cards[4]) + val(m_cards[5])) % 10;
        return {m_cards[0], m_cards[1], m_cards[2], m_cards[3], m_cards[4], m_cards[5],
                4'(ps), 4'(ds), 4'(val(m_cards[2])), 3'(m_count), m_err};
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input logic [5:0] s, input logic [3:0] rank, input logic rst);
        @(negedge slow_clock);
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = s;
        new_card = rank;
        resetb   = rst;
        @(posedge slow_clock);
        #1;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'b0;
        resetb = 1'b0;
        model_step(s, rank, rst);
        $display("txn strobes=%b rank=%0d rst=%0b -> p=%0d/%0d/%0d d=%0d/%0d/%0d ps=%0d ds=%0d n=%0d err=%0b",
                 s, rank, rst, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
                 pscore, dscore, cards_dealt, proto_err);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd5, 1'b1);       // reset wins over a strobe
        vectors++;
        if (obs !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_state got=%h want=%h", obs, 40'h0);
        end
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_model got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_natural();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd9, 1'b0);
        vectors++;
        if (pcard1 !== 4'd9 || pscore !== 4'd9 || cards_dealt !== 3'd1) begin
            miscompares++;
            $display("FAIL natural_latency got=%0d/%0d/%0d want=9/9/1", pcard1, pscore, cards_dealt);
        end
        step(D1, 4'd3, 1'b0);
        step(P2, 4'd13, 1'b0);
        step(D2, 4'd4, 1'b0);
        vectors++;
        if (pscore !== 4'd9 || dscore !== 4'd7 || cards_dealt !== 3'd4 || proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL natural_scores got ps=%0d ds=%0d n=%0d err=%0b want 9 7 4 0",
                     pscore, dscore, cards_dealt, proto_err);
        end
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL natural_model got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_three_card();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd12, 1'b0);
        step(D1, 4'd6, 1'b0);
        step(P2, 4'd5, 1'b0);
        step(D2, 4'd6, 1'b0);
        step(P3, 4'd7, 1'b0);
        step(D3, 4'd10, 1'b0);
        vectors++;
        if (pscore !== 4'd2 || pcard3_val !== 4'd7 || dscore !== 4'd2
            || cards_dealt !== 3'd6 || proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL three_card got ps=%0d p3v=%0d ds=%0d n=%0d err=%0b want 2 7 2 6 0",
                     pscore, pcard3_val, dscore, cards_dealt, proto_err);
        end
        // Terminal state: any further load is a violation and changes nothing.
        step(P3, 4'd1, 1'b0);
        vectors++;
        if (proto_err !== 1'b1 || pcard3 !== 4'd7 || cards_dealt !== 3'd6) begin
            miscompares++;
            $display("FAIL three_card_terminal got err=%0b p3=%0d n=%0d want 1 7 6",
                     proto_err, pcard3, cards_dealt);
        end
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL three_card_model got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_dealer_third();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'($urandom_range(1, 13)), 1'b0);
        step(D1, 4'($urandom_range(1, 13)), 1'b0);
        step(P2, 4'($urandom_range(1, 13)), 1'b0);
        step(D2, 4'($urandom_range(1, 13)), 1'b0);
        step(D3, 4'd1, 1'b0);
        vectors++;
        if (dcard3 !== 4'd1 || pcard3 !== 4'd0 || cards_dealt !== 3'd5 || proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL dealer_third got d3=%0d p3=%0d n=%0d err=%0b want 1 0 5 0",
                     dcard3, pcard3, cards_dealt, proto_err);
        end
        // Player may not draw after the dealer's third card.
        step(P3, 4'd4, 1'b0);
        vectors++;
        if (pcard3 !== 4'd0 || proto_err !== 1'b1 || cards_dealt !== 3'd5) begin
            miscompares++;
            $display("FAIL dealer_third_late_p3 got p3=%0d err=%0b n=%0d want 0 1 5",
                     pcard3, proto_err, cards_dealt);
        end
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL dealer_third_model got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_violation();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd8, 1'b0);
        step(D1 | P2, 4'd2, 1'b0);
        vectors++;
        if (proto_err !== 1'b1 || dcard1 !== 4'd0 || pcard2 !== 4'd0 || cards_dealt !== 3'd1) begin
            miscompares++;
            $display("FAIL multi_strobe got err=%0b d1=%0d p2=%0d n=%0d want 1 0 0 1",
                     proto_err, dcard1, pcard2, cards_dealt);
        end
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd8, 1'b0);
        step(P1, 4'd3, 1'b0);
        vectors++;
        if (proto_err !== 1'b1 || pcard1 !== 4'd8 || cards_dealt !== 3'd1) begin
            miscompares++;
            $display("FAIL reload_p1 got err=%0b p1=%0d n=%0d want 1 8 1",
                     proto_err, pcard1, cards_dealt);
        end
        // State was held, so the expected next card is still taken.
        step(D1, 4'd2, 1'b0);
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL violation_resume got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_reset_mid_hand();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd4, 1'b0);
        step(D1, 4'd5, 1'b0);
        step(P2, 4'd6, 1'b0);
        step(D2, 4'd7, 1'b1);
        vectors++;
        if (obs !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_mid_hand got=%h want=%h", obs, 40'h0);
        end
        step(P1, 4'd2, 1'b0);
        vectors++;
        if (obs !== model_vec() || pcard1 !== 4'd2 || cards_dealt !== 3'd1) begin
            miscompares++;
            $display("FAIL clean_restart got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_bad_rank();
        step(6'b0, 4'd0, 1'b1);
        step(P1, 4'd15, 1'b0);
`ifdef RANK_CHECK_EN
        vectors++;
        if (proto_err !== 1'b1 || pcard1 !== 4'd0 || cards_dealt !== 3'd0) begin
            miscompares++;
            $display("FAIL bad_rank got err=%0b p1=%0d n=%0d want 1 0 0", proto_err, pcard1, cards_dealt);
        end
`else
        vectors++;
        if (pcard1 !== 4'd15 || pscore !== 4'd0 || proto_err !== 1'b0 || cards_dealt !== 3'd1) begin
            miscompares++;
            $display("FAIL bad_rank got p1=%0d ps=%0d err=%0b n=%0d want 15 0 0 1",
                     pcard1, pscore, proto_err, cards_dealt);
        end
`endif
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL bad_rank_model got=%h want=%h", obs, model_vec());
        end
    endtask

    task automatic test_random();
        logic [5:0] s;
        logic [3:0] rank;
        logic       rst;
        int         pick;
        int         legal_slots [$];
        for (int hand = 0; hand < 30; hand++) begin
            step(6'b0, 4'd0, 1'b1);
            for (int k = 0; k < 9; k++) begin
                pick = $urandom_range(0, 9);
                s    = 6'b0;
                if (pick < 7) begin
                    legal_slots.delete();
                    for (int i = 0; i < 6; i++) if (slot_legal(i)) legal_slots.push_back(i);
                    if (legal_slots.size() > 0)
                        s[legal_slots[$urandom_range(0, legal_slots.size() - 1)]] = 1'b1;
                end else if (pick == 7) begin
                    s[$urandom_range(0, 5)] = 1'b1;
                end else if (pick == 9) begin
                    s = 6'($urandom);
                end
                rank = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(1, 13));
                rst  = ($urandom_range(0, 24) == 0);
                step(s, rank, rst);
                vectors++;
                if (obs !== model_vec()) begin
                    miscompares++;
                    $display("FAIL random h=%0d k=%0d got=%h want=%h", hand, k, obs, model_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_three_card();
        test_dealer_third();
        test_violation();
        test_reset_mid_hand();
        test_bad_rank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
